// File: rtl/cla_seq_addsub_pkg.sv
// cla_seq_pkg: shared types and constants for the sequential CLA add/subtract unit.
// Holds the sequencer state encoding, the slice width and the slice-count helper.
// Imported by cla_seq_addsub; the slice module itself is type-free.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SLICE_W = 4;

   // Number of slice cycles needed to sweep an operand of the given width.
   function automatic int nslice(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/cla_seq_addsub_cla4.sv
// CLA_4: 4-bit carry-lookahead adder slice, purely combinational.
// Latency: zero cycles, the result is a function of the current inputs.
// Backpressure: none, no handshake at this level.
module CLA_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       c3
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // Every carry is flattened from generate/propagate terms so none ripples.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s    = p ^ c[3:0];
   assign cout = c[4];
   // The carry into the top bit is exported so the caller can derive signed overflow.
   assign c3   = c[3];

endmodule

// File: rtl/cla_seq_addsub.sv
// cla_seq_addsub: WIDTH-bit add/subtract built from one 4-bit CLA slice, one nibble per clock.
// Latency: out_valid rises WIDTH/4 edges after the accept edge; the result holds until retired.
// Backpressure: result held in DONE while out_ready=0; in_ready is low outside IDLE unless
// CLA_SEQ_BACK_TO_BACK_EN is defined, which lets DONE accept a new request on the retire edge.
module cla_seq_addsub
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = nslice(WIDTH);
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   generate
      if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
         $error("cla_seq_addsub: WIDTH must be a multiple of 4 and at least 8");
      end
   endgenerate

   state_t            state;
   logic [WIDTH-1:0]  opa;
   logic [WIDTH-1:0]  opb;       // B already inverted for subtraction
   logic              carry;     // carry between successive slice cycles
   logic [IDX_W-1:0]  idx;
   logic              zacc;      // running "all nibbles so far are zero"

   logic [SLICE_W-1:0] sl_a;
   logic [SLICE_W-1:0] sl_b;
   logic [SLICE_W-1:0] sl_s;
   logic               sl_cout;
   logic               sl_c3;
   logic               sl_zero;

   logic accept;
   logic retire;

   assign sl_a    = opa[idx*SLICE_W +: SLICE_W];
   assign sl_b    = opb[idx*SLICE_W +: SLICE_W];
   assign sl_zero = (sl_s == '0);

   CLA_4 u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry),
      .s    (sl_s),
      .cout (sl_cout),
      .c3   (sl_c3)
   );

   // Request acceptance: open in IDLE, and optionally in DONE when the result retires.
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         case (state)
            IDLE:    in_ready = 1'b1;
`ifdef CLA_SEQ_BACK_TO_BACK_EN
            DONE:    in_ready = out_ready;
`else
            DONE:    in_ready = 1'b0;
`endif
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign accept = in_valid & in_ready;
   assign retire = out_valid & out_ready;

   // Sequencer: walks the slice across the operands and registers the result and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         idx       <= '0;
         carry     <= 1'b0;
         zacc      <= 1'b0;
         opa       <= '0;
         opb       <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Acceptance is handled below, shared with the DONE fast path.
            end
            RUN: begin
               sum[idx*SLICE_W +: SLICE_W] <= sl_s;
               carry <= sl_cout;
               zacc  <= zacc & sl_zero;
               idx   <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  cout      <= sl_cout;
                  // Signed overflow: carry into the sign bit differs from carry out of it.
                  ovf       <= sl_cout ^ sl_c3;
                  zero      <= zacc & sl_zero;
                  idx       <= '0;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (retire) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // A new request overrides the state update above; in_ready gates where it can happen.
         if (accept) begin
            opa       <= a;
            opb       <= b ^ {WIDTH{sub}};
            carry     <= sub;
            idx       <= '0;
            zacc      <= 1'b1;
            state     <= RUN;
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cla_seq_addsub.sv
// tb_cla_seq_addsub: directed bench for cla_seq_addsub at WIDTH=32.
// Expected results come from a plain 33-bit arithmetic model pushed to a scoreboard queue.
// Build with CLA_SEQ_BACK_TO_BACK_EN defined to also exercise the retire-and-accept edge.
module tb_cla_seq_addsub;

   localparam int W  = 32;
   localparam int NS = W / 4;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   int   checks   = 0;
   int   failures = 0;
   res_t sb[$];

   always #5 clk = ~clk;

   cla_seq_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      res_t       r;
      logic [W-1:0] yx;
      logic [W:0]   t;
      yx     = s ? ~y : y;
      t      = {1'b0, x} + {1'b0, yx} + {{W{1'b0}}, s};
      r.sum  = t[W-1:0];
      r.cout = t[W];
      r.ovf  = (x[W-1] == yx[W-1]) && (t[W-1] != x[W-1]);
      r.zero = (t[W-1:0] == '0);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request once in_ready is seen, and push its expected result.
   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk("ready_timeout", 32'(in_ready), 32'd1);
      a = x; b = y; sub = s; in_valid = 1'b1;
      sb.push_back(model(x, y, s));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges until out_valid, then compare against the oldest scoreboard entry.
   task automatic wait_result(input string tag);
      int   n = 0;
      res_t e;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(NS));
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_sum"},  sum,         e.sum);
         chk({tag, "_cout"}, 32'(cout),   32'(e.cout));
         chk({tag, "_ovf"},  32'(ovf),    32'(e.ovf));
         chk({tag, "_zero"}, 32'(zero),   32'(e.zero));
      end
   endtask

   // With out_ready high, the result retires on the next edge and IDLE reopens in_ready.
   task automatic retire_check(input string tag);
      @(posedge clk); #1;
      chk({tag, "_ovalid_after"}, 32'(out_valid), 32'd0);
      chk({tag, "_iready_after"}, 32'(in_ready),  32'd1);
   endtask

   task automatic full_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s);
      start_op(x, y, s);
      chk({tag, "_iready_run"}, 32'(in_ready), 32'd0);
      wait_result(tag);
      retire_check(tag);
   endtask

   initial begin
      res_t held;
      int   seen;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ovalid", 32'(out_valid), 32'd0);
      chk("rst_sum",    sum,            32'd0);
      chk("rst_cout",   32'(cout),      32'd0);
      chk("rst_ovf",    32'(ovf),       32'd0);
      chk("rst_zero",   32'(zero),      32'd0);
      chk("rst_iready", 32'(in_ready),  32'd0);
      rst = 1'b0;
      #1;
      chk("idle_iready", 32'(in_ready), 32'd1);

      // Basic additions, signed overflow and full carry-out
      full_op("add_1_2",   32'h0000_0001, 32'h0000_0002, 1'b0);
      full_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      full_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      full_op("add_mix",   32'h1234_5678, 32'h89AB_CDEF, 1'b0);

      // Subtraction: equal operands, borrow, negative overflow
      full_op("sub_eq",    32'h0000_0005, 32'h0000_0005, 1'b1);
      full_op("sub_borrow",32'h0000_0000, 32'h0000_0001, 1'b1);
      full_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1);
      full_op("sub_mix",   32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);

      // Backpressure: result held 5 cycles with a competing request pending
      out_ready = 1'b0;
      start_op(32'hCAFE_0000, 32'h0000_BABE, 1'b0);
      held = model(32'hCAFE_0000, 32'h0000_BABE, 1'b0);
      wait_result("bp");
      a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_ovalid", 32'(out_valid), 32'd1);
         chk("bp_hold_sum",    sum,            held.sum);
         chk("bp_hold_iready", 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_retired", 32'(out_valid), 32'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      chk("bp_no_accept", 32'(seen), 32'd0);

      // Reset in the middle of RUN (after slice index 3 is reached)
      start_op(32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      chk("abort_ovalid", 32'(out_valid), 32'd0);
      chk("abort_sum",    sum,            32'd0);
      chk("abort_cout",   32'(cout),      32'd0);
      chk("abort_ovf",    32'(ovf),       32'd0);
      chk("abort_zero",   32'(zero),      32'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
      wait_result("post_rst");
      chk("post_rst_sum_const", sum, 32'h0000_0030);
      retire_check("post_rst");

`ifdef CLA_SEQ_BACK_TO_BACK_EN
      // Retire and accept on the same edge: straight back into RUN
      start_op(32'h0000_0100, 32'h0000_0200, 1'b0);
      wait_result("b2b_first");
      chk("b2b_iready_done", 32'(in_ready), 32'd1);
      start_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
      chk("b2b_ovalid_run", 32'(out_valid), 32'd0);
      chk("b2b_iready_run", 32'(in_ready),  32'd0);
      wait_result("b2b_second");
      retire_check("b2b_second");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
